// File: rtl/pic_step_sequencer_pkg.sv
// rtl/pic_step_sequencer_pkg.sv - shared types and default sizes for the PIC timestep sequencer
package pic_step_sequencer_pkg;

  localparam int DEF_NUM_PARTICLES = 16384;
  localparam int DEF_PADDRWIDTH    = $clog2(DEF_NUM_PARTICLES);
  localparam int DEF_MAX_INFLIGHT  = 32;
  localparam int DEF_STEPWIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCATTER, SCAT_DRAIN, SOLVE, PUSH, PUSH_DRAIN, STEP_END
  } step_state_t;

  typedef enum logic {PH_SCATTER = 1'b0, PH_PUSH = 1'b1} phase_t;

  typedef logic [DEF_PADDRWIDTH-1:0] paddr_t;

endpackage

// File: rtl/pic_issue_credit.sv
// rtl/pic_issue_credit.sv - particle index issue counter with in-flight credit limit and retire error flag
module pic_issue_credit
  import pic_step_sequencer_pkg::*;
#(
  parameter int NUM_PARTICLES = DEF_NUM_PARTICLES,
  parameter int MAX_INFLIGHT  = DEF_MAX_INFLIGHT,
  parameter int PADDRWIDTH    = $clog2(NUM_PARTICLES),
  parameter int CWIDTH        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  start,
  input  logic                  issue_en,
  input  logic                  p_ready,
  input  logic                  p_retire,
  output logic                  p_valid,
  output logic [PADDRWIDTH-1:0] p_addr,
  output logic                  last_accept,
  output logic                  inflight_zero,
  output logic                  err
);

  logic [PADDRWIDTH-1:0] addr_q, addr_d;
  logic [CWIDTH-1:0]     inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic                  aborted_q, aborted_d;
  logic                  accept, retire_ok;

  always_comb begin
    p_valid     = issue_en && (inflight_q < CWIDTH'(MAX_INFLIGHT));
    accept      = p_valid && p_ready;
    last_accept = accept && (addr_q == PADDRWIDTH'(NUM_PARTICLES - 1));
    retire_ok   = p_retire && (inflight_q != '0);
    addr_d      = addr_q;
    inflight_d  = inflight_q;
    err_d       = err_q;
    aborted_d   = aborted_q;

    if (last_accept) addr_d = '0;
    else if (accept) addr_d = addr_q + PADDRWIDTH'(1);

    case ({accept, retire_ok})
      2'b10:   inflight_d = inflight_q + CWIDTH'(1);
      2'b01:   inflight_d = inflight_q - CWIDTH'(1);
      default: inflight_d = inflight_q;
    endcase

    // Retires trailing an abort are stragglers from the abandoned run, not protocol errors.
    if (p_retire && (inflight_q == '0) && !aborted_q) err_d = 1'b1;

    if (start) begin
      err_d     = 1'b0;
      aborted_d = 1'b0;
    end
    if (abort) begin
      addr_d     = '0;
      inflight_d = '0;
      aborted_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
    end
  end

  assign p_addr        = addr_q;
  assign inflight_zero = (inflight_q == '0);
  assign err           = err_q;

endmodule

// File: rtl/pic_step_sequencer.sv
// rtl/pic_step_sequencer.sv - PIC timestep sequencer: clear, scatter, solve, push per step
// Optional PERF_CNT_EN adds per-phase cycle counters and a stall counter.
module pic_step_sequencer
  import pic_step_sequencer_pkg::*;
#(
  parameter int NUM_PARTICLES = DEF_NUM_PARTICLES,
  parameter int PADDRWIDTH    = $clog2(NUM_PARTICLES),
  parameter int MAX_INFLIGHT  = DEF_MAX_INFLIGHT,
  parameter int STEPWIDTH     = DEF_STEPWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEPWIDTH-1:0]  num_steps,
  output logic                  busy,
  output logic                  done,
  output logic [STEPWIDTH-1:0]  step_cnt,
  output logic                  clr_start,
  input  logic                  clr_done,
  output logic                  p_valid,
  input  logic                  p_ready,
  output logic [PADDRWIDTH-1:0] p_addr,
  output logic                  p_phase,
  input  logic                  p_retire,
  output logic                  solve_start,
  input  logic                  solve_done,
  output logic                  err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           scat_cycles,
  output logic [31:0]           solve_cycles,
  output logic [31:0]           push_cycles,
  output logic [31:0]           stall_cycles
`endif
);

  step_state_t          state_q, state_d;
  logic [STEPWIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [STEPWIDTH-1:0] num_steps_q, num_steps_d;
  logic                 clr_start_q, solve_start_q;
  logic                 start_acc, issue_en, last_accept, inflight_zero, final_step;

  always_comb begin
    start_acc   = start && !abort && (state_q == IDLE);
    final_step  = (num_steps_q != '0) && ((step_cnt_q + STEPWIDTH'(1)) == num_steps_q);
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    num_steps_d = num_steps_q;
    done        = 1'b0;
    case (state_q)
      IDLE: if (start_acc) begin
        state_d     = CLEAR;
        step_cnt_d  = '0;
        num_steps_d = num_steps;
      end
      CLEAR:      if (clr_done) state_d = SCATTER;
      SCATTER:    if (last_accept) state_d = SCAT_DRAIN;
      SCAT_DRAIN: if (inflight_zero) state_d = SOLVE;
      SOLVE:      if (solve_done) state_d = PUSH;
      PUSH:       if (last_accept) state_d = PUSH_DRAIN;
      PUSH_DRAIN: if (inflight_zero) state_d = STEP_END;
      STEP_END: begin
        step_cnt_d = step_cnt_q + STEPWIDTH'(1);
        if (final_step) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      step_cnt_d = step_cnt_q;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      step_cnt_q    <= '0;
      num_steps_q   <= '0;
      clr_start_q   <= 1'b0;
      solve_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      num_steps_q   <= num_steps_d;
      clr_start_q   <= (state_d == CLEAR) && (state_q != CLEAR);
      solve_start_q <= (state_d == SOLVE) && (state_q != SOLVE);
    end
  end

  assign issue_en    = (state_q == SCATTER) || (state_q == PUSH);
  assign busy        = (state_q != IDLE);
  assign step_cnt    = step_cnt_q;
  assign clr_start   = clr_start_q;
  assign solve_start = solve_start_q;
  assign p_phase     = ((state_q == PUSH) || (state_q == PUSH_DRAIN)) ? PH_PUSH : PH_SCATTER;

  pic_issue_credit #(
    .NUM_PARTICLES (NUM_PARTICLES),
    .MAX_INFLIGHT  (MAX_INFLIGHT),
    .PADDRWIDTH    (PADDRWIDTH)
  ) u_issue (
    .clk           (clk),
    .rst_n         (rst_n),
    .abort         (abort),
    .start         (start_acc),
    .issue_en      (issue_en),
    .p_ready       (p_ready),
    .p_retire      (p_retire),
    .p_valid       (p_valid),
    .p_addr        (p_addr),
    .last_accept   (last_accept),
    .inflight_zero (inflight_zero),
    .err           (err)
  );

`ifdef PERF_CNT_EN
  // Running counts cover the step in progress; outputs hold the last completed step.
  logic [31:0] scat_run_q, solve_run_q, push_run_q;
  logic [31:0] scat_cyc_q, solve_cyc_q, push_cyc_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scat_run_q  <= '0;
      solve_run_q <= '0;
      push_run_q  <= '0;
      scat_cyc_q  <= '0;
      solve_cyc_q <= '0;
      push_cyc_q  <= '0;
      stall_q     <= '0;
    end else if (start_acc) begin
      scat_run_q  <= '0;
      solve_run_q <= '0;
      push_run_q  <= '0;
      scat_cyc_q  <= '0;
      solve_cyc_q <= '0;
      push_cyc_q  <= '0;
      stall_q     <= '0;
    end else begin
      if ((state_q == SCATTER) || (state_q == SCAT_DRAIN)) scat_run_q <= scat_run_q + 32'd1;
      if (state_q == SOLVE) solve_run_q <= solve_run_q + 32'd1;
      if ((state_q == PUSH) || (state_q == PUSH_DRAIN)) push_run_q <= push_run_q + 32'd1;
      if (state_q == STEP_END) begin
        scat_cyc_q  <= scat_run_q;
        solve_cyc_q <= solve_run_q;
        push_cyc_q  <= push_run_q;
        scat_run_q  <= '0;
        solve_run_q <= '0;
        push_run_q  <= '0;
      end
      if (p_valid && !p_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign scat_cycles  = scat_cyc_q;
  assign solve_cycles = solve_cyc_q;
  assign push_cycles  = push_cyc_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pic_step_sequencer.sv
// tb/tb_pic_step_sequencer.sv - directed self-checking bench for pic_step_sequencer (8 particles, 4 credits)
module tb_pic_step_sequencer;

  localparam int NP = 8;
  localparam int MI = 4;
  localparam int SW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          clr_done = 1'b0;
  logic          p_ready = 1'b0;
  logic          p_retire = 1'b0;
  logic          solve_done = 1'b0;
  logic          busy, done, clr_start, p_valid, p_phase, solve_start, err;
  logic [SW-1:0] step_cnt;
  logic [AW-1:0] p_addr;
`ifdef PERF_CNT_EN
  logic [31:0]   scat_cycles, solve_cycles, push_cycles, stall_cycles;
`endif

  int total = 0;
  int bad = 0;

  // Responder and scoreboard state
  logic       auto_ret = 1'b0;
  logic       auto_done = 1'b0;
  logic       m_retire = 1'b0;
  logic [2:0] pipe = '0;
  int         clr_ctr = 0, solve_ctr = 0;
  int         exp_addr = 0;
  logic       exp_phase = 1'b0;
  int         acc_n = 0, clr_n = 0, solve_n = 0, done_n = 0;

  always #5 clk = ~clk;

  pic_step_sequencer #(
    .NUM_PARTICLES (NP),
    .MAX_INFLIGHT  (MI),
    .STEPWIDTH     (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .num_steps    (num_steps),
    .busy         (busy),
    .done         (done),
    .step_cnt     (step_cnt),
    .clr_start    (clr_start),
    .clr_done     (clr_done),
    .p_valid      (p_valid),
    .p_ready      (p_ready),
    .p_addr       (p_addr),
    .p_phase      (p_phase),
    .p_retire     (p_retire),
    .solve_start  (solve_start),
    .solve_done   (solve_done),
    .err          (err)
`ifdef PERF_CNT_EN
    ,
    .scat_cycles  (scat_cycles),
    .solve_cycles (solve_cycles),
    .push_cycles  (push_cycles),
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive responder inputs, score any accept, then advance to the next falling edge.
  task automatic cyc();
    logic acc;
    p_retire   = m_retire | (auto_ret & pipe[2]);
    clr_done   = (clr_ctr == 1);
    solve_done = (solve_ctr == 1);
    if (clr_ctr != 0) clr_ctr--;
    if (solve_ctr != 0) solve_ctr--;
    acc = p_valid && p_ready && !abort;
    if (acc) begin
      chk("accept_addr", 32'(p_addr), 32'(exp_addr));
      chk("accept_phase", 32'(p_phase), 32'(exp_phase));
      acc_n++;
      if (exp_addr == NP - 1) begin
        exp_addr  = 0;
        exp_phase = ~exp_phase;
      end else begin
        exp_addr++;
      end
    end
    if (done) done_n++;
    if (clr_start) begin
      clr_n++;
      if (auto_done) clr_ctr = 5;
    end
    if (solve_start) begin
      solve_n++;
      if (auto_done) solve_ctr = 5;
    end
    pipe = {pipe[1:0], acc};
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(p_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_step_cnt", 32'(step_cnt), 0);
    chk("rst_clr_start", 32'(clr_start), 0);
    chk("rst_solve_start", 32'(solve_start), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    cyc();

    // Retire with nothing in flight after reset raises a sticky error.
    m_retire = 1'b1;
    cyc();
    m_retire = 1'b0;
    cyc();
    chk("t6_err_set", 32'(err), 1);
    cyc();
    chk("t6_err_hold", 32'(err), 1);

    // Test 1: one full step with free-running responders.
    auto_ret = 1'b1;
    auto_done = 1'b1;
    p_ready = 1'b1;
    num_steps = 16'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_clr_start", 32'(clr_start), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_err_cleared", 32'(err), 0);
    for (int i = 0; i < 300 && done_n == 0; i++) cyc();
    chk("t1_done_seen", 32'(done_n), 1);
    cyc();
    chk("t1_accepts", 32'(acc_n), 16);
    chk("t1_clr_pulses", 32'(clr_n), 1);
    chk("t1_solve_pulses", 32'(solve_n), 1);
    chk("t1_step_cnt", 32'(step_cnt), 1);
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);

    // Test 2: no retires, so credits stop issue after 4 accepts.
    auto_ret = 1'b0;
    acc_n = 0;
    done_n = 0;
    num_steps = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20 && !p_valid; i++) cyc();
    chk("t2_valid_up", 32'(p_valid), 1);
    repeat (8) cyc();
    chk("t2_accepts", 32'(acc_n), 4);
    chk("t2_valid_low", 32'(p_valid), 0);
    chk("t2_addr_hold", 32'(p_addr), 4);
    m_retire = 1'b1;
    cyc();
    m_retire = 1'b0;
    chk("t2_valid_after_retire", 32'(p_valid), 1);
    chk("t2_addr_after_retire", 32'(p_addr), 4);
    cyc();
    chk("t4_full", 32'(p_valid), 0);

    // Test 4: accept and retire together leave credit unchanged; drain waits for the last retire.
    p_ready = 1'b0;
    m_retire = 1'b1;
    cyc();
    p_ready = 1'b1;
    cyc();
    m_retire = 1'b0;
    chk("t4_same_cycle_valid", 32'(p_valid), 1);
    chk("t4_same_cycle_addr", 32'(p_addr), 6);
    cyc();
    chk("t4_full_again", 32'(p_valid), 0);
    chk("t4_addr7", 32'(p_addr), 7);
    m_retire = 1'b1;
    cyc();
    m_retire = 1'b0;
    cyc();
    chk("t4_last_valid", 32'(p_valid), 0);
    chk("t4_addr_reset", 32'(p_addr), 0);
    chk("t4_drain_phase", 32'(p_phase), 0);
    m_retire = 1'b1;
    repeat (3) cyc();
    m_retire = 1'b0;
    cyc();
    chk("t4_drain_wait", 32'(solve_start), 0);
    m_retire = 1'b1;
    cyc();
    m_retire = 1'b0;
    chk("t4_drain_wait2", 32'(solve_start), 0);
    cyc();
    chk("t4_solve_start", 32'(solve_start), 1);

    // Test 3: downstream stalls for 10 cycles at the start of push.
    p_ready = 1'b0;
    for (int i = 0; i < 20 && !p_valid; i++) cyc();
    chk("t3_valid_up", 32'(p_valid), 1);
    repeat (10) cyc();
    chk("t3_valid_held", 32'(p_valid), 1);
    chk("t3_addr_held", 32'(p_addr), 0);
    chk("t3_phase", 32'(p_phase), 1);
`ifdef PERF_CNT_EN
    chk("t3_stall_cycles", stall_cycles, 10);
`endif

    // Test 5: abort in push with index 5 offered.
    auto_ret = 1'b1;
    p_ready = 1'b1;
    for (int i = 0; i < 30 && !(p_valid && p_addr == 3'd5); i++) cyc();
    chk("t5_at_addr5", 32'(p_valid && p_addr == 3'd5), 1);
    p_ready = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    exp_addr = 0;
    exp_phase = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(p_valid), 0);
    chk("t5_addr", 32'(p_addr), 0);
    chk("t5_step_cnt", 32'(step_cnt), 0);
    repeat (4) cyc();
    chk("t5_no_done", 32'(done_n), 0);
    chk("t5_late_retire_no_err", 32'(err), 0);

    // Test 6: three-step run; num_steps sampled only at start.
    p_ready = 1'b1;
    acc_n = 0;
    clr_n = 0;
    solve_n = 0;
    num_steps = 16'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    num_steps = 16'd0;
    chk("t6_clr_start", 32'(clr_start), 1);
    for (int i = 0; i < 600 && done_n == 0; i++) cyc();
    chk("t6_done_seen", 32'(done_n), 1);
    cyc();
    chk("t6_step_cnt", 32'(step_cnt), 3);
    chk("t6_busy_low", 32'(busy), 0);
    chk("t6_accepts", 32'(acc_n), 48);
    chk("t6_clr_pulses", 32'(clr_n), 3);
    chk("t6_solve_pulses", 32'(solve_n), 3);
    chk("t6_err", 32'(err), 0);

    // Asynchronous reset mid-run.
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (12) cyc();
    chk("ar_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_valid", 32'(p_valid), 0);
    chk("ar_step_cnt", 32'(step_cnt), 0);
    chk("ar_clr_start", 32'(clr_start), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
